// File: rtl/bit_stream_packer.sv
// Packs a 1-bit-per-cycle serial stream LSB-first into WIDTH-bit words and
// buffers completed words in a small FIFO behind a valid/ready interface.
module bit_stream_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [$clog2(WIDTH)-1:0]     partial_count,
    output logic                         overflow,
    output logic [7:0]                   drop_count,
    input  logic                         clear_ovf
);

    localparam int PC_W   = $clog2(WIDTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic accept;
    logic word_done;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        accept    = bit_valid & ~flush;
        word_done = accept && (partial_count == PC_W'(WIDTH - 1));
        next_word = {bit_in, shift_reg[WIDTH-1:1]};
        full      = (fill_level == FILL_W'(DEPTH));
        out_valid = (fill_level != '0);
        pop       = out_valid & out_ready;
        push      = word_done & (~full | pop);
        drop      = word_done & full & ~pop;
        // Gate stale storage so an empty FIFO always presents zero.
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Shifting right means the first accepted bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg     <= '0;
            partial_count <= '0;
        end else if (flush) begin
            shift_reg     <= '0;
            partial_count <= '0;
        end else if (accept) begin
            if (word_done) begin
                shift_reg     <= '0;
                partial_count <= '0;
            end else begin
                shift_reg     <= next_word;
                partial_count <= partial_count + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= next_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + FILL_W'(1);
                2'b01:   fill_level <= fill_level - FILL_W'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, so the new event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_ovf) begin
            overflow   <= drop;
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'd255) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed self-checking bench for bit_stream_packer (WIDTH=8, DEPTH=4).
module tb_bit_stream_packer;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill_level;
    logic [2:0] partial_count;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    bit_stream_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .flush         (flush),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fill_level    (fill_level),
        .partial_count (partial_count),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .clear_ovf     (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill_level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
        n_checks++; if (partial_count !== 3'd0) begin n_fail++; $display("FAIL reset_partial got %0d want 0", partial_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drops got %0d want 0", drop_count); end
    endtask

    task automatic test_basic_word();
        logic [7:0] bits;
        bits = 8'b0100_1101;   // sent LSB first: 1,0,1,1,0,0,1,0
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid bit %0d got %b want 0", i, out_valid); end
            send_bit(bits[i]);
            n_checks++;
            if (partial_count !== 3'((i + 1) % 8)) begin
                n_fail++; $display("FAIL basic_partial bit %0d got %0d want %0d", i, partial_count, (i + 1) % 8);
            end
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 8'h4D) begin n_fail++; $display("FAIL basic_data got %h want 4d", out_data); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) send_bit(1'b1);
        n_checks++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill got %0d want 4", fill_level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drops got %0d want 1", drop_count); end
        step(); step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL ovf_hold got %b/%h want 1/ff", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
                n_fail++; $display("FAIL ovf_drain word %0d got %b/%h want 1/ff", i, out_valid, out_data);
            end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", out_valid); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL ovf_clear got %b/%0d want 0/0", overflow, drop_count); end
    endtask

    task automatic test_full_pop();
        logic [7:0] w;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(8'(k));
        n_checks++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill got %0d want 4", fill_level); end
        w = 8'h05;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        out_ready = 1'b1;
        send_bit(w[7]);
        out_ready = 1'b0;
        n_checks++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_level got %0d want 4", fill_level); end
        n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL fullpop_nodrop got %b/%0d want 0/0", overflow, drop_count); end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
                n_fail++; $display("FAIL fullpop_order got %b/%h want 1/%h", out_valid, out_data, 8'(k));
            end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        n_checks++; if (partial_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got %0d want 3", partial_count); end
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        n_checks++; if (partial_count !== 3'd0) begin n_fail++; $display("FAIL flush_partial got %0d want 0", partial_count); end
        n_checks++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL flush_fifo got %0d want 0", fill_level); end
        send_word(8'hA5);
        n_checks++; if (out_data !== 8'hA5 || fill_level !== 3'd1) begin n_fail++; $display("FAIL flush_word got %h/%0d want a5/1", out_data, fill_level); end
        n_checks++; if (partial_count !== 3'd0) begin n_fail++; $display("FAIL flush_post got %0d want 0", partial_count); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        out_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        w = 8'hFF;
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        n_checks++; if (fill_level !== 3'd2 || partial_count !== 3'd5) begin n_fail++; $display("FAIL rstmid_pre got %0d/%0d want 2/5", fill_level, partial_count); end
        rst = 1'b1;
        bit_valid = 1'b1; bit_in = 1'b1;
        step();
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        n_checks++; if (fill_level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifo got %0d/%b want 0/0", fill_level, out_valid); end
        n_checks++; if (partial_count !== 3'd0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_partial got %0d/%h want 0/00", partial_count, out_data); end
        send_word(8'h3C);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_word got %b/%h want 1/3c", out_valid, out_data); end
        n_checks++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL rstmid_level got %0d want 1", fill_level); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_word(8'hC3);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_first got %b/%h want 1/c3", out_valid, out_data); end
        send_word(8'h5A);
        n_checks++; if (out_data !== 8'h5A || fill_level !== 3'd1) begin n_fail++; $display("FAIL b2b_second got %h/%0d want 5a/1", out_data, fill_level); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        logic [7:0] w;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(8'h00);
        for (int k = 0; k < 300; k++) send_word(8'h77);
        n_checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin n_fail++; $display("FAIL sat_count got %0d/%b want 255/1", drop_count, overflow); end
        n_checks++; if (fill_level !== 3'd4 || out_data !== 8'h00) begin n_fail++; $display("FAIL sat_fifo got %0d/%h want 4/00", fill_level, out_data); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        n_checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0d/%b want 0/0", drop_count, overflow); end
        send_word(8'h12);
        send_word(8'h34);
        n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL sat_regrow got %0d want 2", drop_count); end
        w = 8'h56;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        clear_ovf = 1'b1;
        send_bit(w[7]);
        clear_ovf = 1'b0;
        n_checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL sat_clear_drop got %0d/%b want 1/1", drop_count, overflow); end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        test_reset();
        test_basic_word();
        test_overflow();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_stream_packer.md
BIT_STREAM_PACKER -- requirements
Module: bit_stream_packer

Purpose: downstream stage of the compiled single-bit resumption device; packs its 1-bit-per-cycle output stream into WIDTH-bit words behind a buffered valid/ready interface.

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per packed word (legal 2..32).
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port bit_in  input  1: serial data bit, connected to the upstream device's __out0.
REQ-006 SHALL have port bit_valid  input  1: bit_in is sampled this cycle when high.
REQ-007 SHALL have port flush  input  1: discard the partially assembled word.
REQ-008 SHALL have port out_data  output  WIDTH: head-of-FIFO word.
REQ-009 SHALL have port out_valid  output  1: out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1: consumer accepts the word when out_valid and out_ready are both high.
REQ-011 SHALL have port fill_level  output  clog2(DEPTH+1): number of FIFO entries occupied.
REQ-012 SHALL have port partial_count  output  clog2(WIDTH): bits accumulated toward the current word.
REQ-013 SHALL have port overflow  output  1: sticky flag, a completed word was dropped.
REQ-014 SHALL have port drop_count  output  8: saturating count of dropped words.
REQ-015 SHALL have port clear_ovf  input  1: clear overflow and drop_count.

Function
REQ-016 SHALL pack LSB-first: the first accepted bit of a word lands in bit 0, the WIDTH-th in bit WIDTH-1.
REQ-017 SHALL increment partial_count per accepted bit (bit_valid=1, flush=0), wrapping from WIDTH-1 to 0 when the word completes.
REQ-018 SHALL push the completed word into the FIFO in the same cycle its last bit is accepted; out_valid rises the following cycle if the FIFO was empty (1-cycle latency).
REQ-019 SHALL pop the FIFO head on out_valid and out_ready; out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on a push when the FIFO is full and no pop occurs that cycle, drop the new word, set overflow, and increment drop_count (saturating at 255).
REQ-021 SHALL, on a push when full with a simultaneous pop, accept the push; fill_level stays DEPTH and nothing is dropped.
REQ-022 SHALL, on simultaneous push and pop when not full, keep fill_level unchanged.
REQ-023 SHALL, when flush=1, zero the shift register and partial_count, discard that cycle's bit_in, and leave FIFO contents unaffected.
REQ-024 SHALL, on clear_ovf=1 coinciding with a new drop, leave overflow=1 and drop_count=1.
REQ-025 SHALL derive out_valid as fill_level != 0, and present out_data from registered FIFO storage with no combinational path from bit_in.
REQ-026 SHALL keep FIFO read/write pointers wrapping modulo DEPTH, with full/empty distinguished by fill_level.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set partial_count=0, shift register=0, fill_level=0, out_valid=0, out_data=0, overflow=0 and drop_count=0; rst SHALL take priority over all other inputs.
REQ-028 SHALL, on reset mid-word or with a non-empty FIFO, discard all pending bits and words; the first word after reset is built from bits accepted after rst deasserts.

Verification
REQ-029 Bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 -> out_data=0x4D and out_valid=1 for exactly one cycle, one cycle after the 8th bit.
REQ-030 out_ready=0, 40 bits of 1 -> fill_level=4, overflow=1, drop_count=1; then out_ready=1 -> four words of 0xFF in order, then out_valid=0.
REQ-031 Full FIFO, 8th bit of a new word arriving on the same cycle as a pop -> no drop, fill_level stays 4, new word appears last.
REQ-032 Three bits accepted, then flush with bit_valid=1, then 8 bits 0xA5 LSB-first -> out_data=0xA5 and partial_count=0.
REQ-033 rst asserted after 5 bits with 2 words queued -> next cycle fill_level=0, out_valid=0, partial_count=0; following 8 bits produce a correct word.
REQ-034 Drive 300 overflow drops, then clear_ovf -> drop_count holds 255 before the clear, then 0 with overflow=0; clear_ovf coinciding with a drop -> drop_count=1.
